spi_master: RTL and testbench
=============================

# spi_master

SPI mode-0 initiator (CPOL=0, CPHA=0, MSB first) that drives the same four-wire SPI bus our FPGA-side SPI slave answers on. It sits in a system-clock-domain design, accepts a parallel word on a start pulse, and shifts it out on mosi while shifting miso in. When the transfer is done it presents the received word. It serves as the board-to-board link master and as the bench stimulus for the SPI slave.

## Interface
- CLK_DIV, 4, clk cycles per sclk half-period; legal range ≥1.
- DATA_WIDTH, 8, bits per transfer (one ce0 assertion).

- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a transfer; sampled only when busy=0.
- data_outgoing  input  DATA_WIDTH  word to transmit; latched when start is accepted.
- data_incoming  output  DATA_WIDTH  last received word; updated only in the done cycle.
- busy  output  1  high from the cycle after accept through the cycle before done.
- done  output  1  one-cycle pulse at end of transfer.
- sclk  output  1  SPI clock, idle low.
- mosi  output  1  serial out, MSB first.
- miso  input  1  serial in.
- ce0  output  1  chip enable, active low.

## Operation
- The clock is one clk; reset is synchronous and active-high, on ports clk and rst.
- Reset values: sclk=0, ce0=1, mosi=0, busy=0, done=0, data_incoming=0; FSM=IDLE; divider=0.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE, start=1: latch data_outgoing into tx_shift. Go to SETUP. Next cycle: ce0=0, mosi=tx MSB, busy=1.
- Divider: counts 0..CLK_DIV-1 in every non-IDLE state. A "tick" is the cycle where it reaches CLK_DIV-1; the divider then wraps to 0.
- SETUP: on tick, sclk←1 and go to SHIFT. The bit counter is set to DATA_WIDTH-1.
- SHIFT, tick with sclk=1:
  - rx_shift ← {rx_shift[W-2:0], miso}, sampled at the end of the high phase.
  - sclk←0.
  - If bit counter=0, go to HOLD with mosi←0. Otherwise mosi←next tx bit and decrement the bit counter.
- SHIFT, tick with sclk=0: sclk←1.
- HOLD: on tick, ce0←1 and go to GAP.
- GAP: on tick, data_incoming←rx_shift, done=1, busy=0, go to IDLE.
- In IDLE, mosi=0, sclk=0, ce0=1.
- start while busy=1 is ignored: no queuing, latched data unchanged.
- start in the done cycle is accepted (FSM is already IDLE). ce0 then stays high for CLK_DIV+1 cycles.
- rst mid-transfer aborts. Next cycle all outputs are at reset values, no done pulse, and data_incoming is cleared.
- CLK_DIV=1 is legal: sclk = clk/2, each state lasts 1 cycle.

## Timing
- Start accepted at cycle 0 (W=DATA_WIDTH, D=CLK_DIV):
  - ce0 falls at cycle 1.
  - Bit k sclk rising at 1+D(2k+1); falling and sample at 1+D(2k+2).
  - Last falling at 1+2WD.
  - ce0 rises at 1+(2W+1)D.
  - done and data_incoming valid at 1+(2W+2)D.
- Default W=8, D=4: ce0 low cycles 1–68, ce0 high at 69, done at 73.
- mosi changes only on sclk-falling cycles (and at cycle 1). It is stable ≥D cycles around each sclk rising edge.
- Latency start→done: 1+(2W+2)D cycles. Min ce0-high between back-to-back transfers: D+1 cycles.

## Configuration
- SPI_MASTER_LOOPBACK_EN
  - Defined: rx_shift samples mosi instead of miso; the miso port is present but ignored. data_incoming equals the transmitted word. The bus pins still toggle normally.
  - Undefined: normal miso sampling.

## Test plan
- Reset: hold rst 3 cycles mid-idle → sclk=0, ce0=1, mosi=0, busy=0, done=0, data_incoming=0x00.
- Single transfer, D=4, W=8, data_outgoing=0xA5, slave model returns 0x3C:
  - mosi bits sampled at sclk rising edges = 1,0,1,0,0,1,0,1.
  - ce0 low cycles 1–68, 8 sclk pulses, done at cycle 73 only.
  - data_incoming=0x3C.
- start asserted at cycles 10 and 40 during the transfer above → ignored; exactly one done pulse; mosi pattern unchanged.
- Back-to-back: 0x01 then 0x80, start held high through done → second ce0 falls at cycle 74; received words per slave model; two done pulses 73 cycles apart.
- Abort: rst=1 at cycle 30 of a transfer → cycle 31 ce0=1, sclk=0, busy=0, data_incoming=0; no done; new start after reset completes normally.
- D=1 and SPI_MASTER_LOOPBACK_EN defined, miso tied 1, data_outgoing=0x5A → done at cycle 19; data_incoming=0x5A.

Source files
------------

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 initiator (CPOL=0, CPHA=0, MSB first) with a clk-derived sclk.
// Define SPI_MASTER_LOOPBACK_EN to capture mosi instead of miso.
module spi_master #(
    parameter int CLK_DIV    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_outgoing,
    output logic [DATA_WIDTH-1:0] data_incoming,
    output logic                  busy,
    output logic                  done,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  ce0
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         div_q, div_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, din_q, din_d;
    logic                  sclk_q, sclk_d, mosi_q, mosi_d, ce0_q, ce0_d, done_q, done_d;
    logic                  tick, rx_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso;
    assign rx_bit      = mosi_q;
`else
    assign rx_bit = miso;
`endif

    assign tick          = div_q == DW'(CLK_DIV - 1);
    assign busy          = state_q != IDLE;
    assign done          = done_q;
    assign sclk          = sclk_q;
    assign mosi          = mosi_q;
    assign ce0           = ce0_q;
    assign data_incoming = din_q;

    always_comb begin
        state_d = state_q;
        div_d   = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        din_d   = din_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        ce0_d   = ce0_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = SETUP;
                tx_d    = data_outgoing;
                mosi_d  = data_outgoing[DATA_WIDTH-1];
                ce0_d   = 1'b0;
            end
            SETUP: if (tick) begin
                state_d = SHIFT;
                sclk_d  = 1'b1;
                bit_d   = BW'(DATA_WIDTH - 1);
            end
            SHIFT: if (tick) begin
                if (sclk_q) begin
                    // end of the high phase: capture, then present the next bit on the falling edge
                    rx_d   = {rx_q[DATA_WIDTH-2:0], rx_bit};
                    sclk_d = 1'b0;
                    if (bit_q == '0) begin
                        state_d = HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        mosi_d = tx_q[DATA_WIDTH-2];
                        tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
                        bit_d  = bit_q - 1'b1;
                    end
                end else begin
                    sclk_d = 1'b1;
                end
            end
            HOLD: if (tick) begin
                state_d = GAP;
                ce0_d   = 1'b1;
            end
            GAP: if (tick) begin
                state_d = IDLE;
                din_d   = rx_q;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            din_q   <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            ce0_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            din_q   <= din_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            ce0_q   <= ce0_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of reset, transfer timing/data, ignored starts,
// back-to-back transfers, abort, and a CLK_DIV=1 instance with miso wired to mosi.
module tb_spi_master;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic       miso, sclk, mosi, ce0, busy, done;
    logic [7:0] data_outgoing = 8'h00, data_incoming;
    logic       start1 = 1'b0, sclk1, mosi1, ce01, busy1, done1;
    logic [7:0] data1 = 8'h00, din1;

    int         n_cmp = 0, n_bad = 0;
    int         ce0_fall[$], ce0_rise[$], done_at[$];
    logic [7:0] din_at[$], slave_q[$], mosi_words[$];
    int         sclk_rises, busy_cnt, bad_mosi;
    logic [7:0] sbuf = 8'h00, rxcap = 8'h00;
    logic [2:0] sbit = 3'd7;

    always #5 clk = ~clk;

    spi_master u0 (
        .clk(clk), .rst(rst), .start(start), .data_outgoing(data_outgoing),
        .data_incoming(data_incoming), .busy(busy), .done(done),
        .sclk(sclk), .mosi(mosi), .miso(miso), .ce0(ce0)
    );

    spi_master #(.CLK_DIV(1), .DATA_WIDTH(8)) u1 (
        .clk(clk), .rst(rst), .start(start1), .data_outgoing(data1),
        .data_incoming(din1), .busy(busy1), .done(done1),
        .sclk(sclk1), .mosi(mosi1), .miso(mosi1), .ce0(ce01)
    );

    // mode-0 slave: loads its reply on ce0 fall, advances on sclk falling, captures mosi on rising
    assign miso = ce0 ? 1'b0 : sbuf[sbit];
    always @(negedge ce0) begin
        sbuf = 8'hFF;
        if (slave_q.size() > 0) sbuf = slave_q.pop_front();
        sbit = 3'd7;
    end
    always @(negedge sclk) if (!ce0 && sbit != 3'd0) sbit = sbit - 3'd1;
    always @(posedge sclk) if (!ce0) rxcap = {rxcap[6:0], mosi};
    always @(posedge ce0) mosi_words.push_back(rxcap);

    function automatic int qi(input int q[$], input int i);
        return i < q.size() ? q[i] : -1;
    endfunction

    function automatic logic [7:0] qb(input logic [7:0] q[$], input int i);
        return i < q.size() ? q[i] : 8'hxx;
    endfunction

    // caller asserts start in cycle 0; records events for cycles 1..n
    task automatic observe(input int n, input int hold_until, input int pa, input int pb,
                           input logic [7:0] next_data);
        logic pce0, psclk, pmosi;
        ce0_fall.delete(); ce0_rise.delete(); done_at.delete(); din_at.delete(); mosi_words.delete();
        sclk_rises = 0; busy_cnt = 0; bad_mosi = 0;
        pce0 = ce0; psclk = sclk; pmosi = mosi;
        for (int rel = 1; rel <= n; rel++) begin
            @(negedge clk);
            if (!ce0 && pce0) ce0_fall.push_back(rel);
            if (ce0 && !pce0) ce0_rise.push_back(rel);
            if (sclk && !psclk) sclk_rises++;
            if (busy) busy_cnt++;
            if (done) begin done_at.push_back(rel); din_at.push_back(data_incoming); end
            if (mosi !== pmosi && !(psclk && !sclk) && !(!ce0 && pce0)) bad_mosi++;
            pce0 = ce0; psclk = sclk; pmosi = mosi;
            start = (rel < hold_until) || rel == pa || rel == pb;
            data_outgoing = next_data;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (sclk !== 1'b0) begin n_bad++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        n_cmp++; if (ce0 !== 1'b1) begin n_bad++; $display("FAIL reset_ce0: got %b want 1", ce0); end
        n_cmp++; if (mosi !== 1'b0) begin n_bad++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (data_incoming !== 8'h00) begin n_bad++; $display("FAIL reset_din: got %h want 00", data_incoming); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        slave_q.push_back(8'h3C);
        @(negedge clk); data_outgoing = 8'hA5; start = 1'b1;
        observe(80, 1, -1, -1, 8'hA5);
        n_cmp++; if (qb(mosi_words, 0) !== 8'hA5) begin n_bad++; $display("FAIL single_mosi_bits: got %h want a5", qb(mosi_words, 0)); end
        n_cmp++; if (qi(ce0_fall, 0) != 1 || ce0_fall.size() != 1) begin n_bad++; $display("FAIL single_ce0_fall: got %0d want 1", qi(ce0_fall, 0)); end
        n_cmp++; if (qi(ce0_rise, 0) != 69) begin n_bad++; $display("FAIL single_ce0_rise: got %0d want 69", qi(ce0_rise, 0)); end
        n_cmp++; if (sclk_rises != 8) begin n_bad++; $display("FAIL single_sclk_pulses: got %0d want 8", sclk_rises); end
        n_cmp++; if (done_at.size() != 1 || qi(done_at, 0) != 73) begin n_bad++; $display("FAIL single_done: got %0d pulses first %0d want 1 at 73", done_at.size(), qi(done_at, 0)); end
        n_cmp++; if (qb(din_at, 0) !== 8'h3C) begin n_bad++; $display("FAIL single_din: got %h want 3c", qb(din_at, 0)); end
        n_cmp++; if (busy_cnt != 72) begin n_bad++; $display("FAIL single_busy_cycles: got %0d want 72", busy_cnt); end
        n_cmp++; if (bad_mosi != 0) begin n_bad++; $display("FAIL single_mosi_stable: got %0d bad changes want 0", bad_mosi); end
        n_cmp++; if (data_incoming !== 8'h3C) begin n_bad++; $display("FAIL single_din_hold: got %h want 3c", data_incoming); end
    endtask

    task automatic test_ignore_start;
        slave_q.push_back(8'hC3);
        @(negedge clk); data_outgoing = 8'hA5; start = 1'b1;
        observe(80, 1, 10, 40, 8'hFF);
        n_cmp++; if (done_at.size() != 1 || qi(done_at, 0) != 73) begin n_bad++; $display("FAIL ignore_done: got %0d pulses first %0d want 1 at 73", done_at.size(), qi(done_at, 0)); end
        n_cmp++; if (qb(mosi_words, 0) !== 8'hA5) begin n_bad++; $display("FAIL ignore_mosi_bits: got %h want a5", qb(mosi_words, 0)); end
        n_cmp++; if (ce0_fall.size() != 1) begin n_bad++; $display("FAIL ignore_ce0_falls: got %0d want 1", ce0_fall.size()); end
        n_cmp++; if (qb(din_at, 0) !== 8'hC3) begin n_bad++; $display("FAIL ignore_din: got %h want c3", qb(din_at, 0)); end
    endtask

    task automatic test_back_to_back;
        slave_q.push_back(8'h5E); slave_q.push_back(8'h81);
        @(negedge clk); data_outgoing = 8'h01; start = 1'b1;
        observe(150, 74, -1, -1, 8'h80);
        n_cmp++; if (qi(ce0_fall, 1) != 74 || ce0_fall.size() != 2) begin n_bad++; $display("FAIL b2b_second_ce0_fall: got %0d (n=%0d) want 74", qi(ce0_fall, 1), ce0_fall.size()); end
        n_cmp++; if (qi(ce0_fall, 1) - qi(ce0_rise, 0) != 5) begin n_bad++; $display("FAIL b2b_ce0_gap: got %0d want 5", qi(ce0_fall, 1) - qi(ce0_rise, 0)); end
        n_cmp++; if (done_at.size() != 2 || qi(done_at, 0) != 73 || qi(done_at, 1) != 146) begin n_bad++; $display("FAIL b2b_done: got %0d pulses at %0d,%0d want 73,146", done_at.size(), qi(done_at, 0), qi(done_at, 1)); end
        n_cmp++; if (qb(din_at, 0) !== 8'h5E || qb(din_at, 1) !== 8'h81) begin n_bad++; $display("FAIL b2b_din: got %h,%h want 5e,81", qb(din_at, 0), qb(din_at, 1)); end
        n_cmp++; if (qb(mosi_words, 0) !== 8'h01 || qb(mosi_words, 1) !== 8'h80) begin n_bad++; $display("FAIL b2b_mosi_words: got %h,%h want 01,80", qb(mosi_words, 0), qb(mosi_words, 1)); end
    endtask

    task automatic test_abort;
        int dcnt;
        slave_q.delete(); slave_q.push_back(8'h11); slave_q.push_back(8'h22);
        @(negedge clk); data_outgoing = 8'h77; start = 1'b1;
        for (int rel = 1; rel <= 30; rel++) begin
            @(negedge clk);
            start = 1'b0;
            if (rel == 30) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (ce0 !== 1'b1) begin n_bad++; $display("FAIL abort_ce0: got %b want 1", ce0); end
        n_cmp++; if (sclk !== 1'b0) begin n_bad++; $display("FAIL abort_sclk: got %b want 0", sclk); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (mosi !== 1'b0) begin n_bad++; $display("FAIL abort_mosi: got %b want 0", mosi); end
        n_cmp++; if (data_incoming !== 8'h00) begin n_bad++; $display("FAIL abort_din: got %h want 00", data_incoming); end
        dcnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        n_cmp++; if (dcnt != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dcnt); end
        data_outgoing = 8'h3A; start = 1'b1;
        observe(80, 1, -1, -1, 8'h3A);
        n_cmp++; if (done_at.size() != 1 || qi(done_at, 0) != 73) begin n_bad++; $display("FAIL abort_restart_done: got %0d pulses first %0d want 1 at 73", done_at.size(), qi(done_at, 0)); end
        n_cmp++; if (qb(din_at, 0) !== 8'h22) begin n_bad++; $display("FAIL abort_restart_din: got %h want 22", qb(din_at, 0)); end
        n_cmp++; if (qb(mosi_words, 0) !== 8'h3A) begin n_bad++; $display("FAIL abort_restart_mosi: got %h want 3a", qb(mosi_words, 0)); end
    endtask

    task automatic test_clkdiv1;
        int first_done, dcnt, rise, sclk_cnt;
        logic pce0, psclk;
        logic [7:0] got;
        first_done = -1; dcnt = 0; rise = -1; sclk_cnt = 0; got = 8'hxx;
        @(negedge clk); data1 = 8'h5A; start1 = 1'b1;
        pce0 = ce01; psclk = sclk1;
        for (int rel = 1; rel <= 30; rel++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (done1) begin
                dcnt++;
                if (first_done < 0) begin first_done = rel; got = din1; end
            end
            if (ce01 && !pce0 && rise < 0) rise = rel;
            if (sclk1 && !psclk) sclk_cnt++;
            pce0 = ce01; psclk = sclk1;
        end
        n_cmp++; if (dcnt != 1 || first_done != 19) begin n_bad++; $display("FAIL div1_done: got %0d pulses first %0d want 1 at 19", dcnt, first_done); end
        n_cmp++; if (got !== 8'h5A) begin n_bad++; $display("FAIL div1_din: got %h want 5a", got); end
        n_cmp++; if (rise != 18) begin n_bad++; $display("FAIL div1_ce0_rise: got %0d want 18", rise); end
        n_cmp++; if (sclk_cnt != 8) begin n_bad++; $display("FAIL div1_sclk_pulses: got %0d want 8", sclk_cnt); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        test_single;
        repeat (3) @(negedge clk);
        test_ignore_start;
        repeat (3) @(negedge clk);
        test_back_to_back;
        repeat (3) @(negedge clk);
        test_abort;
        repeat (3) @(negedge clk);
        test_clkdiv1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
